// File: rtl/svm_stream.sv
// rtl/svm_stream.sv - streaming linear-SVM classifier, one label per modality
// Optional feature: define SVM_SCORE_OUT_EN to expose raw per-mode scores on dout_score.

module svm_stream #(
    parameter int NBITS     = 9,
    parameter int F_WIDTH   = 214,
    parameter int NPARALLEL = 2,
    parameter int NMODES    = 2,
    parameter int MAX_SUP   = 160,
    parameter int SW        = $clog2(MAX_SUP + 1),
    parameter int ACC_W     = 3 * NBITS + $clog2(F_WIDTH) + $clog2(MAX_SUP) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fin_valid,
    output logic                      fin_ready,
    input  logic [NMODES*SW-1:0]      in_nsup,
    input  logic [NMODES*ACC_W-1:0]   in_intercept,
    input  logic                      feat_valid,
    output logic                      feat_ready,
    input  logic [NPARALLEL*NBITS-1:0] feat_data,
    input  logic                      sv_valid,
    output logic                      sv_ready,
    input  logic [NPARALLEL*NBITS-1:0] sv_data,
    input  logic [NBITS-1:0]          sv_alpha,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic [NMODES-1:0]         dout_label
`ifdef SVM_SCORE_OUT_EN
    ,
    output logic [NMODES*ACC_W-1:0]   dout_score
`endif
);

    localparam int FBEATS = F_WIDTH / NPARALLEL;
    localparam int BW     = (FBEATS > 1) ? $clog2(FBEATS) : 1;
    localparam int MW     = (NMODES > 1) ? $clog2(NMODES) : 1;
    localparam int DOT_W  = 2 * NBITS + $clog2(F_WIDTH);
    localparam int LANE_W = NPARALLEL * NBITS;

    generate
        if (F_WIDTH % NPARALLEL != 0) begin : g_bad_width
            $error("svm_stream: F_WIDTH must be a multiple of NPARALLEL");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, FEAT, SV, DRAIN, OUT} state_t;

    state_t state, state_nxt;

    logic [LANE_W-1:0]        feat_buf [FBEATS];
    logic [BW-1:0]            feat_cnt;
    logic [BW-1:0]            sv_beat;
    logic [SW-1:0]            sv_cnt;
    logic [SW-1:0]            nsup_q [NMODES];
    logic signed [ACC_W-1:0]  intercept_q [NMODES];
    logic signed [ACC_W-1:0]  score [NMODES];
    logic [MW-1:0]            mode;
    logic                     drain_cnt;
    logic [NMODES-1:0]        label_q;

    logic                     p_valid;
    logic                     p_last;
    logic signed [DOT_W-1:0]  p_sum;
    logic signed [NBITS-1:0]  p_alpha;
    logic signed [DOT_W-1:0]  dot_acc;

    logic                     fin_hs, feat_hs, sv_hs, dout_hs;
    logic                     feat_last, sv_beat_last, vec_all_done, mode_last;
    logic [SW-1:0]            nsup_cur;
    logic signed [DOT_W-1:0]  beat_sum;
    logic signed [DOT_W-1:0]  dot_next;
    logic signed [ACC_W-1:0]  score_add;

    assign fin_hs       = fin_valid && fin_ready;
    assign feat_hs      = feat_valid && feat_ready;
    assign sv_hs        = sv_valid && sv_ready;
    assign dout_hs      = dout_valid && dout_ready;
    assign nsup_cur     = nsup_q[mode];
    assign feat_last    = (feat_cnt == BW'(FBEATS - 1));
    assign sv_beat_last = (sv_beat == BW'(FBEATS - 1));
    assign vec_all_done = sv_beat_last && (sv_cnt == nsup_cur - SW'(1));
    assign mode_last    = (mode == MW'(NMODES - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (fin_hs) state_nxt = FEAT;
            FEAT:  if (feat_hs && feat_last) state_nxt = (nsup_cur != '0) ? SV : DRAIN;
            SV:    if (sv_hs && vec_all_done) state_nxt = DRAIN;
            DRAIN: if (drain_cnt) state_nxt = mode_last ? OUT : FEAT;
            OUT:   if (dout_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        fin_ready  = (state == IDLE) && !rst;
        feat_ready = (state == FEAT);
        sv_ready   = (state == SV);
        dout_valid = (state == OUT);
    end

    assign dout_label = label_q;

    // Lane products of one support beat against the stored feature beat
    always_comb begin
        beat_sum = '0;
        for (int l = 0; l < NPARALLEL; l++) begin
            beat_sum = beat_sum
                     + DOT_W'($signed(feat_buf[sv_beat][l*NBITS +: NBITS]))
                     * DOT_W'($signed(sv_data[l*NBITS +: NBITS]));
        end
    end

    assign dot_next  = dot_acc + p_sum;
    assign score_add = ACC_W'(p_alpha) * ACC_W'(dot_next);

    always_ff @(posedge clk) begin
        if (feat_hs) begin
            feat_buf[feat_cnt] <= feat_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            feat_cnt  <= '0;
            sv_beat   <= '0;
            sv_cnt    <= '0;
            mode      <= '0;
            drain_cnt <= 1'b0;
            label_q   <= '0;
            p_valid   <= 1'b0;
            p_last    <= 1'b0;
            p_sum     <= '0;
            p_alpha   <= '0;
            dot_acc   <= '0;
            for (int m = 0; m < NMODES; m++) begin
                nsup_q[m]      <= '0;
                intercept_q[m] <= '0;
                score[m]       <= '0;
            end
        end else begin
            p_valid <= sv_hs;
            p_last  <= sv_hs && sv_beat_last;
            if (sv_hs) begin
                p_sum <= beat_sum;
                if (sv_beat_last) begin
                    p_alpha <= $signed(sv_alpha);
                end
            end

            // Second pipeline stage: fold beat into dot, retire vector into score
            if (p_valid) begin
                if (p_last) begin
                    score[mode] <= score[mode] + score_add;
                    dot_acc     <= '0;
                end else begin
                    dot_acc <= dot_next;
                end
            end

            case (state)
                IDLE: begin
                    if (fin_hs) begin
                        mode     <= '0;
                        label_q  <= '0;
                        feat_cnt <= '0;
                        sv_beat  <= '0;
                        sv_cnt   <= '0;
                        dot_acc  <= '0;
                        for (int m = 0; m < NMODES; m++) begin
                            nsup_q[m] <= (in_nsup[m*SW +: SW] > SW'(MAX_SUP))
                                       ? SW'(MAX_SUP) : in_nsup[m*SW +: SW];
                            intercept_q[m] <= $signed(in_intercept[m*ACC_W +: ACC_W]);
                            score[m]       <= (m == 0) ? $signed(in_intercept[m*ACC_W +: ACC_W])
                                                       : '0;
                        end
                    end
                end
                FEAT: begin
                    if (feat_hs) begin
                        feat_cnt <= feat_last ? '0 : feat_cnt + BW'(1);
                    end
                end
                SV: begin
                    if (sv_hs) begin
                        sv_beat <= sv_beat_last ? '0 : sv_beat + BW'(1);
                        if (sv_beat_last) begin
                            sv_cnt <= sv_cnt + SW'(1);
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= ~drain_cnt;
                    if (drain_cnt) begin
                        label_q[mode] <= ~score[mode][ACC_W-1];
                        if (!mode_last) begin
                            mode                 <= mode + MW'(1);
                            score[mode + MW'(1)] <= intercept_q[mode + MW'(1)];
                            sv_cnt               <= '0;
                            sv_beat              <= '0;
                        end
                    end
                end
                OUT: begin
                    if (dout_hs) begin
                        label_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SVM_SCORE_OUT_EN
    generate
        for (genvar g = 0; g < NMODES; g++) begin : g_score_out
            assign dout_score[g*ACC_W +: ACC_W] = score[g];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_svm_stream.sv
// tb/tb_svm_stream.sv - randomized self-checking bench for svm_stream against a dot-product model

module tb_svm_stream;

    localparam int NBITS     = 4;
    localparam int F_WIDTH   = 4;
    localparam int NPARALLEL = 2;
    localparam int NMODES    = 2;
    localparam int MAX_SUP   = 4;
    localparam int SW        = $clog2(MAX_SUP + 1);
    localparam int ACC_W     = 3 * NBITS + $clog2(F_WIDTH) + $clog2(MAX_SUP) + 1;
    localparam int FBEATS    = F_WIDTH / NPARALLEL;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        fin_valid = 1'b0;
    logic                        fin_ready;
    logic [NMODES*SW-1:0]        in_nsup = '0;
    logic [NMODES*ACC_W-1:0]     in_intercept = '0;
    logic                        feat_valid = 1'b0;
    logic                        feat_ready;
    logic [NPARALLEL*NBITS-1:0]  feat_data = '0;
    logic                        sv_valid = 1'b0;
    logic                        sv_ready;
    logic [NPARALLEL*NBITS-1:0]  sv_data = '0;
    logic [NBITS-1:0]            sv_alpha = '0;
    logic                        dout_valid;
    logic                        dout_ready = 1'b0;
    logic [NMODES-1:0]           dout_label;
`ifdef SVM_SCORE_OUT_EN
    logic [NMODES*ACC_W-1:0]     dout_score;
`endif

    svm_stream #(
        .NBITS(NBITS), .F_WIDTH(F_WIDTH), .NPARALLEL(NPARALLEL),
        .NMODES(NMODES), .MAX_SUP(MAX_SUP)
    ) dut (
        .clk(clk), .rst(rst),
        .fin_valid(fin_valid), .fin_ready(fin_ready),
        .in_nsup(in_nsup), .in_intercept(in_intercept),
        .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_data(feat_data),
        .sv_valid(sv_valid), .sv_ready(sv_ready), .sv_data(sv_data), .sv_alpha(sv_alpha),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_label(dout_label)
`ifdef SVM_SCORE_OUT_EN
        , .dout_score(dout_score)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int last_hs_cyc = 0;

    int feat    [NMODES][F_WIDTH];
    int sup     [NMODES][MAX_SUP][F_WIDTH];
    int alpha_v [NMODES][MAX_SUP];
    int nsup_in [NMODES];
    int icpt    [NMODES];

    bit mon_en = 1'b0;
    int sv_ready_seen = 0;
    always @(negedge clk) if (mon_en && sv_ready) sv_ready_seen <= sv_ready_seen + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp_nsup(input int n);
        return (n > MAX_SUP) ? MAX_SUP : n;
    endfunction

    // Reference: score = intercept + sum over vectors of alpha * <features, support>
    function automatic longint model_score(input int m);
        longint s = icpt[m];
        for (int v = 0; v < clamp_nsup(nsup_in[m]); v++) begin
            longint dot = 0;
            for (int i = 0; i < F_WIDTH; i++) dot += feat[m][i] * sup[m][v][i];
            s += alpha_v[m][v] * dot;
        end
        return s;
    endfunction

    function automatic int rnd_elem();
        return int'($urandom_range(0, 15)) - 8;
    endfunction

    task automatic gen_random_job();
        for (int m = 0; m < NMODES; m++) begin
            nsup_in[m] = $urandom_range(0, 6);
            icpt[m]    = int'($urandom_range(0, 4000)) - 2000;
            for (int i = 0; i < F_WIDTH; i++) feat[m][i] = rnd_elem();
            for (int v = 0; v < MAX_SUP; v++) begin
                alpha_v[m][v] = rnd_elem();
                for (int i = 0; i < F_WIDTH; i++) sup[m][v][i] = rnd_elem();
            end
        end
    endtask

    task automatic fill_job(input int n0, input int n1, input int i0, input int i1,
                            input int fv, input int sval, input int av);
        nsup_in[0] = n0; nsup_in[1] = n1; icpt[0] = i0; icpt[1] = i1;
        for (int m = 0; m < NMODES; m++) begin
            for (int i = 0; i < F_WIDTH; i++) feat[m][i] = fv;
            for (int v = 0; v < MAX_SUP; v++) begin
                alpha_v[m][v] = av;
                for (int i = 0; i < F_WIDTH; i++) sup[m][v][i] = sval;
            end
        end
    endtask

    task automatic do_fin();
        int n = 0;
        for (int m = 0; m < NMODES; m++) begin
            in_nsup[m*SW +: SW]            = SW'(nsup_in[m]);
            in_intercept[m*ACC_W +: ACC_W] = ACC_W'(icpt[m]);
        end
        fin_valid = 1'b1;
        while (!fin_ready && n < 50) begin @(negedge clk); n++; end
        if (!fin_ready) chk("fin_wait", longint'(fin_ready), 1);
        @(negedge clk);
        fin_valid = 1'b0;
    endtask

    task automatic send_feats(input int m, input int gap);
        for (int b = 0; b < FBEATS; b++) begin
            int n = 0;
            while (int'($urandom_range(0, 99)) < gap) @(negedge clk);
            for (int l = 0; l < NPARALLEL; l++)
                feat_data[l*NBITS +: NBITS] = NBITS'(feat[m][b*NPARALLEL + l]);
            feat_valid = 1'b1;
            while (!feat_ready && n < 50) begin @(negedge clk); n++; end
            if (!feat_ready) begin
                chk("feat_wait", longint'(feat_ready), 1);
                feat_valid = 1'b0;
                return;
            end
            last_hs_cyc = cyc;
            @(negedge clk);
            feat_valid = 1'b0;
        end
    endtask

    // Alpha is only meaningful on the last beat of a vector; other beats carry junk
    task automatic send_svs(input int m, input int gap, input int max_beats);
        int total = clamp_nsup(nsup_in[m]) * FBEATS;
        if (max_beats < total) total = max_beats;
        for (int k = 0; k < total; k++) begin
            int n = 0;
            int v = k / FBEATS;
            int b = k % FBEATS;
            while (int'($urandom_range(0, 99)) < gap) @(negedge clk);
            for (int l = 0; l < NPARALLEL; l++)
                sv_data[l*NBITS +: NBITS] = NBITS'(sup[m][v][b*NPARALLEL + l]);
            sv_alpha = (b == FBEATS - 1) ? NBITS'(alpha_v[m][v]) : NBITS'($urandom);
            sv_valid = 1'b1;
            while (!sv_ready && n < 50) begin @(negedge clk); n++; end
            if (!sv_ready) begin
                chk("sv_wait", longint'(sv_ready), 1);
                sv_valid = 1'b0;
                return;
            end
            last_hs_cyc = cyc;
            @(negedge clk);
            sv_valid = 1'b0;
        end
    endtask

    task automatic run_job(input string tag, input int gap, input int stall);
        longint exp_s [NMODES];
        longint exp_label = 0;
        int n = 0;
        for (int m = 0; m < NMODES; m++) begin
            exp_s[m] = model_score(m);
            if (exp_s[m] >= 0) exp_label |= (64'd1 << m);
        end
        do_fin();
        for (int m = 0; m < NMODES; m++) begin
            send_feats(m, gap);
            if (clamp_nsup(nsup_in[m]) > 0) send_svs(m, gap, MAX_SUP * FBEATS);
        end
        while (!dout_valid && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_valid"}, longint'(dout_valid), 1);
        chk({tag, "_latency"}, cyc - last_hs_cyc, 3);
        chk({tag, "_label"}, longint'(dout_label), exp_label);
`ifdef SVM_SCORE_OUT_EN
        for (int m = 0; m < NMODES; m++) begin
            logic signed [ACC_W-1:0] sc;
            sc = dout_score[m*ACC_W +: ACC_W];
            chk({tag, "_score"}, longint'(sc), exp_s[m]);
        end
`endif
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_stall_valid"}, longint'(dout_valid), 1);
            chk({tag, "_stall_label"}, longint'(dout_label), exp_label);
            chk({tag, "_stall_fin_ready"}, longint'(fin_ready), 0);
        end
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        chk({tag, "_post_valid"}, longint'(dout_valid), 0);
        chk({tag, "_post_label"}, longint'(dout_label), 0);
        chk({tag, "_post_fin_ready"}, longint'(fin_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_feat_ready", longint'(feat_ready), 0);
        chk("rst_sv_ready", longint'(sv_ready), 0);
        chk("rst_dout_valid", longint'(dout_valid), 0);
        chk("rst_dout_label", longint'(dout_label), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_fin_ready", longint'(fin_ready), 1);

        // Stray beats offered in IDLE must not be taken
        feat_valid = 1'b1; sv_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_feat_ready", longint'(feat_ready), 0);
        chk("idle_sv_ready", longint'(sv_ready), 0);
        feat_valid = 1'b0; sv_valid = 1'b0;

        fill_job(1, 1, -7, -9, 1, 1, 2);
        run_job("basic", 0, 0);

        fill_job(0, 0, 0, -1, 1, 1, 1);
        sv_valid = 1'b1; sv_ready_seen = 0; mon_en = 1'b1;
        run_job("nsup0", 0, 0);
        mon_en = 1'b0; sv_valid = 1'b0;
        chk("nsup0_sv_ready_seen", sv_ready_seen, 0);

        fill_job(4, 4, 0, 0, -8, -8, -8);
        run_job("extreme", 0, 0);

        gen_random_job();
        run_job("stall", 0, 10);

        for (int j = 0; j < 20; j++) begin
            gen_random_job();
            run_job("rand_nogap", 0, 0);
            run_job("rand_gap", 40, 0);
        end

        // Reset in the middle of mode-1 support streaming
        gen_random_job();
        nsup_in[0] = 1; nsup_in[1] = 2;
        do_fin();
        send_feats(0, 0);
        send_svs(0, 0, MAX_SUP * FBEATS);
        send_feats(1, 0);
        send_svs(1, 0, 1);
        rst = 1'b1;
        #1;
        chk("midrst_feat_ready", longint'(feat_ready), 0);
        chk("midrst_sv_ready", longint'(sv_ready), 0);
        chk("midrst_dout_valid", longint'(dout_valid), 0);
        chk("midrst_dout_label", longint'(dout_label), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_fin_ready", longint'(fin_ready), 1);
        @(negedge clk);
        chk("midrst_no_dout", longint'(dout_valid), 0);
        run_job("after_rst", 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
